// File: rtl/alu_sequencer_if.sv
// Bus between the ALU sequencer and its datapath/memory.
//   master : sequencer side (drives strobes, selects and status; receives Start, MemAck, MDR)
//   slave  : datapath/environment side
// Signals:
//   Start, MemAck, MDR[31:0]              request, memory acknowledge, instruction source
//   encIn[31:0], Rin[15:0]                one-hot bus-source select, register write enables
//   Read, MDRin, Yin, ZLOin, PCinc, MemReq datapath/memory strobes
//   NOT, OR, AND, SHR, SHRA, SHL, ADD     ALU operation selects
//   Busy, Done, IllegalOp                 status
interface alu_sequencer_if;
  logic        Start;
  logic        MemAck;
  logic [31:0] MDR;
  logic [31:0] encIn;
  logic [15:0] Rin;
  logic        Read;
  logic        MDRin;
  logic        Yin;
  logic        ZLOin;
  logic        PCinc;
  logic        MemReq;
  logic        NOT;
  logic        OR;
  logic        AND;
  logic        SHR;
  logic        SHRA;
  logic        SHL;
  logic        ADD;
  logic        Busy;
  logic        Done;
  logic        IllegalOp;

  modport master (
    input  Start, MemAck, MDR,
    output encIn, Rin, Read, MDRin, Yin, ZLOin, PCinc, MemReq,
    output NOT, OR, AND, SHR, SHRA, SHL, ADD,
    output Busy, Done, IllegalOp
  );

  modport slave (
    output Start, MemAck, MDR,
    input  encIn, Rin, Read, MDRin, Yin, ZLOin, PCinc, MemReq,
    input  NOT, OR, AND, SHR, SHRA, SHL, ADD,
    input  Busy, Done, IllegalOp
  );
endinterface

// File: rtl/alu_sequencer.sv
// Control sequencer for a bus-based ALU datapath. Fetches one instruction word per Start,
// decodes opcode/Ra/Rb/Rc and steps the datapath through Rb->Y, Rc op Y -> ZLO, ZLO -> Ra.
// Ports:
//   Clock : sole clock, rising edge
//   Clear : asynchronous active-low reset
//   bus   : alu_sequencer_if.master (handshake, instruction word, strobes, selects, status)
// All outputs are a Moore decode of the state register and the latched instruction fields.
module alu_sequencer (
  input logic            Clock,
  input logic            Clear,
  alu_sequencer_if.master bus
);

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpShr  = 5'b00111;
  localparam logic [4:0] OpShra = 5'b01000;
  localparam logic [4:0] OpShl  = 5'b01001;
  localparam logic [4:0] OpNot  = 5'b10010;

  localparam int unsigned EncZlo = 19;
  localparam int unsigned EncMdr = 21;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] opcode_q, opcode_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic [3:0] rc_q, rc_d;

  logic legal_op;
  logic is_not;

  // Low MDR bits carry no instruction fields.
  logic unused_mdr;
  assign unused_mdr = ^bus.MDR[14:0];

  assign legal_op = opcode_q inside {OpAdd, OpAnd, OpOr, OpShr, OpShra, OpShl, OpNot};
  assign is_not   = (opcode_q == OpNot);

  // State and field registers
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
    end
  end

  // Next-state and field capture
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    unique case (state_q)
      StIdle:  if (bus.Start) state_d = StFetch;
      StFetch: if (bus.MemAck) state_d = StT1;
      StT1: begin
        // MDR holds the fetched word by now; capture fields on the way out.
        opcode_d = bus.MDR[31:27];
        ra_d     = bus.MDR[26:23];
        rb_d     = bus.MDR[22:19];
        rc_d     = bus.MDR[18:15];
        state_d  = StT2;
      end
      StT2: begin
        if (!legal_op)   state_d = StIdle;
        else if (is_not) state_d = StT4;  // single operand: no Y load
        else             state_d = StT3;
      end
      StT3:    state_d = StT4;
      StT4:    state_d = StT5;
      StT5:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  logic [31:0] enc_in;
  logic [15:0] rin;
  logic        read, mdr_in, y_in, zlo_in, pc_inc, mem_req;
  logic        alu_not, alu_or, alu_and, alu_shr, alu_shra, alu_shl, alu_add;
  logic        busy, done, illegal_op;

  always_comb begin
    enc_in     = '0;
    rin        = '0;
    read       = 1'b0;
    mdr_in     = 1'b0;
    y_in       = 1'b0;
    zlo_in     = 1'b0;
    pc_inc     = 1'b0;
    mem_req    = 1'b0;
    alu_not    = 1'b0;
    alu_or     = 1'b0;
    alu_and    = 1'b0;
    alu_shr    = 1'b0;
    alu_shra   = 1'b0;
    alu_shl    = 1'b0;
    alu_add    = 1'b0;
    done       = 1'b0;
    illegal_op = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StIdle: ;
      StFetch: begin
        mem_req = 1'b1;
        read    = 1'b1;
        mdr_in  = 1'b1;
      end
      StT1: begin
        enc_in[EncMdr] = 1'b1;
        pc_inc         = 1'b1;
      end
      StT2: illegal_op = !legal_op;
      StT3: begin
        enc_in[rb_q] = 1'b1;
        y_in         = 1'b1;
      end
      StT4: begin
        if (is_not) enc_in[rb_q] = 1'b1;
        else        enc_in[rc_q] = 1'b1;
        zlo_in = 1'b1;
        case (opcode_q)
          OpAdd:   alu_add  = 1'b1;
          OpAnd:   alu_and  = 1'b1;
          OpOr:    alu_or   = 1'b1;
          OpShr:   alu_shr  = 1'b1;
          OpShra:  alu_shra = 1'b1;
          OpShl:   alu_shl  = 1'b1;
          OpNot:   alu_not  = 1'b1;
          default: ;
        endcase
      end
      StT5: begin
        enc_in[EncZlo] = 1'b1;
        rin[ra_q]      = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.encIn     = enc_in;
  assign bus.Rin       = rin;
  assign bus.Read      = read;
  assign bus.MDRin     = mdr_in;
  assign bus.Yin       = y_in;
  assign bus.ZLOin     = zlo_in;
  assign bus.PCinc     = pc_inc;
  assign bus.MemReq    = mem_req;
  assign bus.NOT       = alu_not;
  assign bus.OR        = alu_or;
  assign bus.AND       = alu_and;
  assign bus.SHR       = alu_shr;
  assign bus.SHRA      = alu_shra;
  assign bus.SHL       = alu_shl;
  assign bus.ADD       = alu_add;
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.IllegalOp = illegal_op;

endmodule
